syncgen: RTL
============

# syncgen

VGA raster timing generator for the 640x480 display path. Runs on the pixel clock (PCK from the MMCM) and produces the horizontal/vertical pixel counters plus registered HS, VS and DE. The pattern generator consumes these to colour pixels and forward sync. It contains only timing, no pixel data path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
- HS_POL, 1'b0, asserted level of HS (0 = active-low)
- VS_POL, 1'b0, asserted level of VS (0 = active-low)

Ports:
- CLK  in  1  pixel clock (PCK, 25 MHz nominal)
- RST  in  1  reset; one clock, asynchronous, active-high
- HCNT  out  10  horizontal counter, 0..H_TOTAL-1
- VCNT  out  10  vertical counter, 0..V_TOTAL-1
- HS  out  1  horizontal sync, polarity per HS_POL
- VS  out  1  vertical sync, polarity per VS_POL
- DE  out  1  data enable, high in active area
- FSTART  out  1  one-cycle pulse at first active pixel of each frame

## Operation
- HCNT increments every CLK; at H_TOTAL-1 wraps to 0.
- VCNT increments only on the cycle HCNT wraps; at V_TOTAL-1 (with HCNT wrap) wraps to 0.
- Active area: HCNT < H_ACTIVE and VCNT < V_ACTIVE.
- HS asserted while H_ACTIVE+H_FP <= HCNT < H_ACTIVE+H_FP+H_SYNC (656..751 default).
- VS asserted while V_ACTIVE+V_FP <= VCNT < V_ACTIVE+V_FP+V_SYNC (490..491 default); VS transitions are line-aligned (change together with the HCNT 799->0 wrap, delayed per Timing).
- DE high in active area, low elsewhere.
- FSTART high for exactly one cycle per frame, decoded from HCNT==0 and VCNT==0.
- Counter widths: 10 bits, sufficient for H_TOTAL <= 1024 and V_TOTAL <= 1024; parameter sets exceeding that are illegal (elaboration-time assertion).
- No enable input; free-running from reset release.

## Timing
- Reset (async assert): HCNT=0, VCNT=0, HS=~HS_POL, VS=~VS_POL, DE=0, FSTART=0. Outputs hold while RST high.
- First rising CLK after RST deasserts: HCNT becomes 1; DE becomes 1 and FSTART becomes 1 (decoded from HCNT=0/VCNT=0 of the prior cycle).
- HCNT/VCNT: registered counters, latency 0 (value is current position).
- HS/VS/DE/FSTART: registered decodes of HCNT/VCNT, latency exactly 1 CLK behind the counters. The pattern stage must use the counters and delay its colour by one register to align with DE.
- Frame period: H_TOTAL*V_TOTAL = 420000 CLK; line period 800 CLK.
- Wrap corner: at HCNT=799, VCNT=524 next cycle is HCNT=0, VCNT=0; FSTART pulses one cycle later.
- RST asserted mid-frame: all outputs go to reset values immediately (async); restart from HCNT=0/VCNT=0 on release, no partial-line artefacts held over.

## Structure
- Package vga_timing_pkg: default 640x480@60 timing localparams (H_*/V_* values, totals), counter width localparam (10), derived sync start/end constants.
- Sub-module natural: syncgen_axis — one counter axis (count, wrap, sync and active decode), instantiated twice; horizontal instance increments every cycle, vertical instance enabled by horizontal wrap.
- syncgen top: two syncgen_axis instances plus output registers for HS/VS/DE/FSTART and polarity application.

## Test plan
- Reset: hold RST high 20 cycles -> HCNT=0, VCNT=0, HS=1, VS=1, DE=0, FSTART=0 throughout.
- Line timing: run one line from release -> DE high 640 cycles, low 160; HS low for 96 cycles starting the cycle after HCNT=656; HCNT wraps 799->0 and VCNT 0->1 at the same edge.
- Frame timing: run 2 frames -> VS low exactly 2 lines (1600 cycles) starting one cycle after VCNT=490,HCNT=0; FSTART pulses exactly twice, 420000 cycles apart; DE count per frame = 307200.
- Wrap corner: observe HCNT=799,VCNT=524 -> next HCNT=0,VCNT=0; FSTART=1 on the following cycle only.
- Mid-frame reset: assert RST at HCNT=300,VCNT=200 asynchronously between edges -> outputs reset before next edge; after release, first FSTART one cycle after release, next 420000 cycles later.
- Polarity: HS_POL=1, VS_POL=1 -> reset HS=0,VS=0; HS high for cycles aligned with 657..752 (one-cycle lag); all other checks unchanged.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the 640x480@60 display path.
// Module parameters default to these values so other modes can override them per instance.
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int CNT_LIMIT = 1 << CNT_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Terminal count of an axis with the given period, sized to the counter.
  function automatic logic [CNT_W-1:0] last_count(input int total);
    return CNT_W'(total - 1);
  endfunction

endpackage

// File: rtl/syncgen_axis.sv
// One raster axis: a wrapping position counter plus its sync, active and origin decodes.
// The decodes are combinational; the top registers them so they trail the counter by one clock.
module syncgen_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             in_sync,
  output logic             in_active,
  output logic             at_origin
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;
  localparam logic [CNT_W-1:0] LAST = last_count(TOTAL);

  if (TOTAL > CNT_LIMIT || TOTAL < 2) begin : g_total_check
    $error("syncgen_axis: period %0d does not fit the %0d-bit counter", TOTAL, CNT_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Compare in 32-bit space so a sync end equal to the full counter range still decodes.
  always_comb begin
    in_active = int'(cnt) < ACTIVE;
    in_sync   = (int'(cnt) >= SYNC_START) && (int'(cnt) < SYNC_END);
    at_origin = (cnt == '0);
  end

endmodule

// File: rtl/syncgen.sv
// VGA raster timing generator: free-running H/V counters with registered HS, VS, DE and FSTART.
// The registered strobes lag the counters by exactly one pixel clock.
module syncgen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [CNT_W-1:0] HCNT,
  output logic [CNT_W-1:0] VCNT,
  output logic             HS,
  output logic             VS,
  output logic             DE,
  output logic             FSTART
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = last_count(H_TOTAL);

  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_size_check
    $error("syncgen: %0dx%0d raster exceeds %0d-bit counters", H_TOTAL, V_TOTAL, CNT_W);
  end

  logic h_wrap;
  logic h_sync;
  logic h_active;
  logic h_origin;
  logic v_sync;
  logic v_active;
  logic v_origin;

  // The line counter advances on the same edge that the pixel counter wraps.
  assign h_wrap = (HCNT == H_LAST);

  syncgen_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (CLK),
    .rst       (RST),
    .en        (1'b1),
    .cnt       (HCNT),
    .in_sync   (h_sync),
    .in_active (h_active),
    .at_origin (h_origin)
  );

  syncgen_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (CLK),
    .rst       (RST),
    .en        (h_wrap),
    .cnt       (VCNT),
    .in_sync   (v_sync),
    .in_active (v_active),
    .at_origin (v_origin)
  );

  // Strobes are decoded from the current counters and registered, so they describe the previous pixel.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HS     <= ~HS_POL;
      VS     <= ~VS_POL;
      DE     <= 1'b0;
      FSTART <= 1'b0;
    end else begin
      HS     <= h_sync ? HS_POL : ~HS_POL;
      VS     <= v_sync ? VS_POL : ~VS_POL;
      DE     <= h_active && v_active;
      FSTART <= h_origin && v_origin;
    end
  end

endmodule
